alu_operand_stage: RTL and testbench

Execute-entry pipeline stage that sits directly upstream of the ALU.
- Accepts decoded ALU instructions from decode over a valid/ready handshake.
- Forms the ALU B operand: register, sign-extended imm5, or zero-extended imm4 shift amount.
- Normalises shift amounts and illegal opcodes.
- Holds results in a 2-entry skid buffer whose output registers drive the ALU's aluop/a/b inputs directly.

---
 rtl/alu_operand_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_operand_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ALU operand stage: registers decoded ALU instructions in front of the ALU.
// Forms the B operand (register, sext imm5 or zext imm4), masks shift
// amounts, folds illegal opcodes to pass/zero and buffers results in a
// two-entry skid buffer. The main entry drives the ALU inputs directly.
module alu_operand_stage #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_aluop,
  input  logic [WIDTH-1:0] in_sr1,
  input  logic [WIDTH-1:0] in_sr2,
  input  logic [5:0]       in_imm,
  input  logic [1:0]       in_bsel,
  input  logic [2:0]       in_dest,
  input  logic             in_setcc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPW-1:0]   out_aluop,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_dest,
  output logic             out_setcc,
  output logic             err_illegal
);

  // ALU opcode encodings used by the operand logic.
  localparam logic [OPW-1:0] OP_PASS    = OPW'(3);
  localparam logic [OPW-1:0] OP_SLL     = OPW'(4);
  localparam logic [OPW-1:0] OP_SRL     = OPW'(5);
  localparam logic [OPW-1:0] OP_SRA     = OPW'(6);
  localparam logic [OPW-1:0] OP_ILLEGAL = OPW'(7);

  // B operand source selector.
  typedef enum logic [1:0] {
    BSEL_REG  = 2'd0,
    BSEL_SEXT = 2'd1,
    BSEL_ZEXT = 2'd2,
    BSEL_REG2 = 2'd3
  } bsel_e;

  // One buffered instruction as it will be presented to the ALU.
  typedef struct packed {
    logic [OPW-1:0]   aluop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       dest;
    logic             setcc;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   err_q, err_d;

  entry_t formed;
  logic   in_is_illegal;
  logic   in_fire;
  logic   main_free;

  // imm[5] is part of the instruction field but no operand uses it.
  logic unused_imm5;
  assign unused_imm5 = in_imm[5];

  // Ready depends on state only, so decode never sees a combinational path
  // from the downstream ready.
  assign in_ready  = ~skid_valid_q;
  assign in_fire   = in_valid & in_ready;
  assign main_free = ~main_valid_q | out_ready;

  assign in_is_illegal = (in_aluop == OP_ILLEGAL);

  // Build the ALU-ready entry from the incoming decoded instruction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    formed       = '0;
    formed.a     = in_sr1;
    formed.dest  = in_dest;
    formed.setcc = in_setcc;
    formed.aluop = in_aluop;

    unique case (bsel_e'(in_bsel))
      BSEL_SEXT: formed.b = {{(WIDTH-5){in_imm[4]}}, in_imm[4:0]};
      BSEL_ZEXT: formed.b = {{(WIDTH-4){1'b0}}, in_imm[3:0]};
      BSEL_REG,
      BSEL_REG2: formed.b = in_sr2;
      default:   formed.b = in_sr2;
    endcase

    // Shifts only ever use the low four bits as the shift amount.
    if (in_aluop == OP_SLL || in_aluop == OP_SRL || in_aluop == OP_SRA) begin
      formed.b = {{(WIDTH-4){1'b0}}, formed.b[3:0]};
    end

    // An illegal opcode becomes a harmless pass of zero.
    if (in_is_illegal) begin
      formed.aluop = OP_PASS;
      formed.b     = '0;
    end
  end

  // Next-state for the two-entry skid buffer and the sticky error flag.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    err_d        = err_q;

    if (flush) begin
      // Redirect: drop everything buffered and whatever arrives this cycle.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (main_free) begin
        if (skid_valid_q) begin
          // Older skid entry moves up; in_ready was low so nothing new arrives.
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          main_d       = formed;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        // Main is stalled: park the new entry in the skid slot.
        skid_d       = formed;
        skid_valid_d = 1'b1;
      end

      if (in_fire && in_is_illegal) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too because the ALU inputs must read zero out of reset.
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      err_q        <= err_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_aluop   = main_q.aluop;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_dest    = main_q.dest;
  assign out_setcc   = main_q.setcc;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios followed by random
// traffic. A predictor pushes expected entries on every input handshake,
// and a monitor compares and pops them as the stage presents them.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_aluop;
  logic [15:0] in_sr1;
  logic [15:0] in_sr2;
  logic [5:0]  in_imm;
  logic [1:0]  in_bsel;
  logic [2:0]  in_dest;
  logic        in_setcc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_aluop;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [2:0]  out_dest;
  logic        out_setcc;
  logic        err_illegal;

  alu_operand_stage #(.WIDTH(16), .OPW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluop   (in_aluop),
    .in_sr1     (in_sr1),
    .in_sr2     (in_sr2),
    .in_imm     (in_imm),
    .in_bsel    (in_bsel),
    .in_dest    (in_dest),
    .in_setcc   (in_setcc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_aluop  (out_aluop),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_dest   (out_dest),
    .out_setcc  (out_setcc),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  aluop;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
    logic        setcc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the ALU should see for one decoded instruction.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] sr1,
                                 input logic [15:0] sr2, input logic [5:0] imm,
                                 input logic [1:0] bsel, input logic [2:0] dest,
                                 input logic setcc);
    exp_t e;
    int   bval;
    int   low5;
    case (bsel)
      2'd1: begin
        low5 = int'(imm) % 32;
        if (low5 >= 16) low5 = low5 - 32;
        bval = low5 & 'hFFFF;
      end
      2'd2:    bval = int'(imm) % 16;
      default: bval = int'(sr2);
    endcase
    if (op >= 3'd4 && op <= 3'd6) bval = bval % 16;
    e.aluop = op;
    if (op == 3'd7) begin
      e.aluop = 3'd3;
      bval    = 0;
    end
    e.a     = sr1;
    e.b     = 16'(bval);
    e.dest  = dest;
    e.setcc = setcc;
    return e;
  endfunction

  // Predictor: record the expected entry whenever an input handshake will happen.
  always @(negedge clk) begin
    if (!rst_n || flush) sb_q.delete();
    else if (in_valid && in_ready)
      sb_q.push_back(model(in_aluop, in_sr1, in_sr2, in_imm, in_bsel, in_dest, in_setcc));
  end

  // Monitor: occupancy/error model plus in-order comparison of presented entries.
  int count    = 0;
  bit err_m    = 1'b0;
  bit chk_zero = 1'b0;
  always @(negedge clk) begin
    bit   out_f;
    bit   in_f;
    exp_t e;
    if (chk_zero) begin
      check("reset_out_aluop", 32'(out_aluop), 32'd0);
      check("reset_out_a", 32'(out_a), 32'd0);
      check("reset_out_b", 32'(out_b), 32'd0);
      check("reset_out_dest", 32'(out_dest), 32'd0);
      check("reset_out_setcc", 32'(out_setcc), 32'd0);
      chk_zero = 1'b0;
    end
    check("out_valid", 32'(out_valid), 32'(count > 0));
    check("in_ready", 32'(in_ready), 32'(count < 2));
    check("err_illegal", 32'(err_illegal), 32'(err_m));
    if (!rst_n) begin
      count    = 0;
      err_m    = 1'b0;
      chk_zero = 1'b1;
    end else if (flush) begin
      count = 0;
    end else begin
      if (count > 0) begin
        if (sb_q.size() == 0) begin
          check("scoreboard_nonempty", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q[0];
          check("out_aluop", 32'(out_aluop), 32'(e.aluop));
          check("out_a", 32'(out_a), 32'(e.a));
          check("out_b", 32'(out_b), 32'(e.b));
          check("out_dest", 32'(out_dest), 32'(e.dest));
          check("out_setcc", 32'(out_setcc), 32'(e.setcc));
        end
      end
      out_f = (count > 0) && out_ready;
      in_f  = in_valid && (count < 2);
      if (in_f && in_aluop == 3'd7) err_m = 1'b1;
      if (out_f && sb_q.size() > 0) void'(sb_q.pop_front());
      count = count - int'(out_f) + int'(in_f);
    end
  end

  task automatic drive(input logic [2:0] op, input logic [15:0] s1, input logic [15:0] s2,
                       input logic [5:0] imm, input logic [1:0] bs, input logic [2:0] d,
                       input logic sc);
    in_valid = 1'b1;
    in_aluop = op;
    in_sr1   = s1;
    in_sr2   = s2;
    in_imm   = imm;
    in_bsel  = bs;
    in_dest  = d;
    in_setcc = sc;
  endtask

  // Offer one instruction and hold it until the stage takes it (bounded).
  task automatic send(input logic [2:0] op, input logic [15:0] s1, input logic [15:0] s2,
                      input logic [5:0] imm, input logic [1:0] bs, input logic [2:0] d,
                      input logic sc);
    drive(op, s1, s2, imm, bs, d, sc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Overall time bound so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(3'd0, 16'hAAAA, 16'h5555, 6'h3F, 2'd1, 3'd5, 1'b1);
    idle(2);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle(2);

    // ADD with sign-extended immediate, downstream always ready.
    out_ready = 1'b1;
    send(3'd0, 16'h1234, 16'h0000, 6'h1F, 2'd1, 3'd1, 1'b1);
    idle(3);

    // Shift amount masking from register and from zext immediate.
    send(3'd6, 16'h8000, 16'h0013, 6'h00, 2'd0, 3'd2, 1'b0);
    send(3'd4, 16'h0001, 16'hFFFF, 6'h3A, 2'd2, 3'd3, 1'b1);
    send(3'd2, 16'h00FF, 16'hCAFE, 6'h15, 2'd3, 3'd4, 1'b1);
    idle(3);

    // Backpressure: A and B fill the buffer, C waits until released.
    out_ready = 1'b0;
    send(3'd1, 16'h0A0A, 16'h1111, 6'h01, 2'd0, 3'd1, 1'b0);
    send(3'd5, 16'h0B0B, 16'h2222, 6'h2C, 2'd2, 3'd2, 1'b1);
    drive(3'd3, 16'h0C0C, 16'h3333, 6'h10, 2'd1, 3'd3, 1'b0);
    idle(4);
    out_ready = 1'b1;
    send(3'd3, 16'h0C0C, 16'h3333, 6'h10, 2'd1, 3'd3, 1'b0);
    idle(4);

    // Flush with both entries full, then a fresh instruction.
    out_ready = 1'b0;
    send(3'd0, 16'h1111, 16'h0001, 6'h00, 2'd0, 3'd6, 1'b1);
    send(3'd0, 16'h2222, 16'h0002, 6'h00, 2'd0, 3'd7, 1'b1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(1);
    out_ready = 1'b1;
    send(3'd1, 16'h4321, 16'h00F0, 6'h0F, 2'd0, 3'd2, 1'b0);
    idle(2);

    // Flush with one entry held and a new input offered the same cycle.
    out_ready = 1'b0;
    send(3'd0, 16'h3333, 16'h0003, 6'h00, 2'd0, 3'd1, 1'b0);
    drive(3'd0, 16'h4444, 16'h0004, 6'h00, 2'd0, 3'd1, 1'b0);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Illegal opcode: pass of zero, sticky error survives a flush.
    send(3'd7, 16'h0102, 16'hBEEF, 6'h00, 2'd0, 3'd4, 1'b1);
    idle(2);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(2);

    // Random traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_aluop  = 3'($urandom_range(0, 7));
      in_sr1    = 16'($urandom);
      in_sr2    = 16'($urandom);
      in_imm    = 6'($urandom);
      in_bsel   = 2'($urandom_range(0, 3));
      in_dest   = 3'($urandom);
      in_setcc  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      idle(1);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Reset clears the sticky error.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
